dmem_responder: RTL

- Data-memory responder at the far end of the MEM-stage control path; consumes memRead/memWrite-style requests from the pipeline.
- Accepts one word access and models a configurable access latency.
- Holds the pipeline with stall_o until the access completes, then returns read data and a one-cycle ack.
- Wraps a word-addressed RAM array and flags misaligned or illegal requests.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_t   : responder FSM states (IDLE, BUSY, DONE)
//   op_t      : latched request kind (OP_RD, OP_WR, OP_ERR)
//   DMEM_*    : default widths and latency
//   sat_inc32 : saturating increment used by the optional perf counters
package dmem_pkg;

  localparam int DMEM_ADDR_W      = 32;
  localparam int DMEM_DATA_W      = 32;
  localparam int DMEM_DEPTH       = 256;
  localparam int DEFAULT_LATENCY  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_ERR = 2'd2
  } op_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x DATA_W word RAM.
//   clk   : rising-edge clock
//   we    : write enable, wdata stored at addr on the edge
//   re    : read enable, word at addr registered onto rdata on the edge
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, holds between reads
module dmem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage and its read register have no reset; clearing a RAM array
  // would turn it into a flop bank. Consumers mask rdata until a real read.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata     <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder with modelled latency.
// One word access is accepted in IDLE, held in BUSY for LATENCY cycles,
// committed on the last BUSY edge and acknowledged for one cycle in DONE.
//   clk, rst_n      : clock, asynchronous active-low reset
//   mem_read_i      : load request
//   mem_write_i     : store request (both asserted = illegal request)
//   addr_i, wdata_i : byte address and store data
//   rdata_o         : load data, valid with ack_o
//   stall_o         : combinational pipeline hold
//   ack_o, err_o    : completion pulse and error flag (misaligned/illegal)
// Optional macro DMEM_PERF_EN adds rd_cnt_o, wr_cnt_o, stall_cnt_o
// (32-bit saturating; error acks are not counted).
// LATENCY must be in 1..15.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              ack_o,
  output logic              err_o
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  op_t                op_q;
  logic [IDX_W+1:0]   addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               rdata_zero_q;
  logic [DATA_W-1:0]  arr_rdata;

  logic req, capture, commit, req_err;
  logic arr_we, arr_re;

  // Address bits above the array span are ignored (addresses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[ADDR_W-1:IDX_W+2];

  assign req     = mem_read_i | mem_write_i;
  assign req_err = (op_q == OP_ERR) || (addr_q[1:0] != 2'b00);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    ack_o   = 1'b0;
    capture = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          stall_o = 1'b1;
          capture = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ack_o   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A request held across reset must not leak through as a stall.
    if (!rst_n) stall_o = 1'b0;
  end

  assign err_o = ack_o && req_err;

  // Request capture and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      cnt_q   <= CNT_LOAD;
      op_q    <= (mem_read_i && mem_write_i) ? OP_ERR :
                 (mem_write_i ? OP_WR : OP_RD);
      addr_q  <= addr_i[IDX_W+1:0];
      wdata_q <= wdata_i;
    end else if (state_q == BUSY && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Array is touched only by legal accesses; errors leave it untouched.
  assign arr_we = commit && (op_q == OP_WR) && !req_err;
  assign arr_re = commit && (op_q == OP_RD) && !req_err;

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (addr_q[IDX_W+1:2]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // The array read register is not reset, so rdata_o is forced to zero after
  // reset and after an error completion until the next good read commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 rdata_zero_q <= 1'b1;
    else if (commit && req_err) rdata_zero_q <= 1'b1;
    else if (arr_re)            rdata_zero_q <= 1'b0;
  end

  assign rdata_o = rdata_zero_q ? '0 : arr_rdata;

`ifdef DMEM_PERF_EN
  logic rd_ack, wr_ack;
  assign rd_ack = ack_o && !req_err && (op_q == OP_RD);
  assign wr_ack = ack_o && !req_err && (op_q == OP_WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_o    <= '0;
      wr_cnt_o    <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (rd_ack)  rd_cnt_o    <= sat_inc32(rd_cnt_o);
      if (wr_ack)  wr_cnt_o    <= sat_inc32(wr_cnt_o);
      if (stall_o) stall_cnt_o <= sat_inc32(stall_cnt_o);
    end
  end
`endif

endmodule
